// File: rtl/load_align_unit.sv
// load_align_unit: memory-stage load aligner/merger over a BUS_BYTES-wide
// read port; one load at a time, split into two beats when it crosses a word.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   req_valid/ready/addr/op/orig  load request (orig = old rt for LWL/LWR)
//   bus_req_valid/ready/addr      aligned bus read request
//   bus_resp_valid/data           bus read data, byte i at [8i+7:8i]
//   resp_valid/ready/data/err     formatted result, err => data 0
module load_align_unit #(
    parameter int BUS_BYTES    = 4,
    parameter bit UNALIGNED_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    input  logic [2:0]             req_op,
    input  logic [31:0]            req_orig,
    output logic                   bus_req_valid,
    input  logic                   bus_req_ready,
    output logic [31:0]            bus_req_addr,
    input  logic                   bus_resp_valid,
    input  logic [8*BUS_BYTES-1:0] bus_resp_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_data,
    output logic                   resp_err
);
    localparam int BW = 8 * BUS_BYTES;
    localparam int OW = $clog2(BUS_BYTES);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_RSV = 3'd5;
    localparam logic [2:0] OP_LWL = 3'd6;
    localparam logic [2:0] OP_LWR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] off_q, off_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   orig_q, orig_d;
    logic [31:0]   baddr_q, baddr_d;
    logic [31:0]   data_q, data_d;
    logic [BW-1:0] beat0_q, beat0_d;
    logic          err_q, err_d;

    logic [2*BW-1:0] stream;
    logic [OW-1:0]   lane_off;
    logic [31:0]     win, word, fmt;
    logic [4:0]      size, last, shk;
    logic            mis, bad;

    assign req_ready     = (state_q == S_IDLE);
    assign bus_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign bus_req_addr  = baddr_q;
    assign resp_valid    = (state_q == S_RESP);
    assign resp_data     = data_q;
    assign resp_err      = err_q;

    // Result formatting from the beat(s) on the bus this cycle.
    always_comb begin
        // In WAIT1 beat0 is the low half of the byte stream.
        if (state_q == S_WAIT1) begin
            stream = {bus_resp_data, beat0_q};
        end else begin
            stream = {{BW{1'b0}}, bus_resp_data};
        end
        lane_off = off_q & ~OW'(3);
        win      = stream[{off_q, 3'b000} +: 32];
        word     = stream[{lane_off, 3'b000} +: 32];
        shk      = {off_q[1:0], 3'b000};
        case (op_q)
            OP_LB:   fmt = {{24{win[7]}}, win[7:0]};
            OP_LBU:  fmt = {24'd0, win[7:0]};
            OP_LH:   fmt = {{16{win[15]}}, win[15:0]};
            OP_LHU:  fmt = {16'd0, win[15:0]};
            OP_LW:   fmt = win;
            OP_LWL:  fmt = (word << (5'd24 - shk))
                         | (orig_q & (32'h00FF_FFFF >> shk));
            OP_LWR:  fmt = (word >> shk)
                         | (orig_q & ~(32'hFFFF_FFFF >> shk));
            default: fmt = '0;
        endcase
        case (op_q)
            OP_LH, OP_LHU: size = 5'd2;
            OP_LW:         size = 5'd4;
            default:       size = 5'd1;
        endcase
        last = 5'(off_q) + size;
    end

    // Request screening: reserved opcode or misaligned without split support.
    always_comb begin
        case (req_op)
            OP_LH, OP_LHU: mis = req_addr[0];
            OP_LW:         mis = |req_addr[1:0];
            default:       mis = 1'b0;
        endcase
        bad = (req_op == OP_RSV) || (!UNALIGNED_EN && mis);
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        op_d    = op_q;
        orig_d  = orig_q;
        baddr_d = baddr_q;
        data_d  = data_q;
        beat0_d = beat0_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d  = req_addr[OW-1:0];
                    op_d   = req_op;
                    orig_d = req_orig;
                    if (bad) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        baddr_d = req_addr & ~32'(BUS_BYTES - 1);
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: begin
                if (bus_req_ready) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (bus_resp_valid) begin
                    beat0_d = bus_resp_data;
                    if (last > 5'(BUS_BYTES)) begin
                        baddr_d = baddr_q + 32'(BUS_BYTES);
                        state_d = S_REQ1;
                    end else begin
                        data_d  = fmt;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ1: begin
                if (bus_req_ready) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (bus_resp_valid) begin
                    data_d  = fmt;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            op_q    <= '0;
            orig_q  <= '0;
            baddr_q <= '0;
            data_q  <= '0;
            beat0_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            op_q    <= op_d;
            orig_q  <= orig_d;
            baddr_q <= baddr_d;
            data_q  <= data_d;
            beat0_q <= beat0_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: three load_align_unit configurations (4B, 8B, 4B no
// unaligned) against a byte-addressed memory and a byte-stream load model.
module tb_load_align_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    logic        req_valid[3];
    logic        req_ready[3];
    logic [31:0] req_addr[3];
    logic [2:0]  req_op[3];
    logic [31:0] req_orig[3];
    logic        bvalid[3];
    logic        bready[3];
    logic [31:0] baddr[3];
    logic        brv[3];
    logic [63:0] bdata[3];
    logic        rvalid[3];
    logic        rready[3];
    logic [31:0] rdata[3];
    logic        rerr[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BB = (g == 1) ? 8 : 4;
        localparam bit UE = (g == 2) ? 1'b0 : 1'b1;
        load_align_unit #(.BUS_BYTES(BB), .UNALIGNED_EN(UE)) u_dut (
            .clk           (clk),
            .resetn        (resetn),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_addr      (req_addr[g]),
            .req_op        (req_op[g]),
            .req_orig      (req_orig[g]),
            .bus_req_valid (bvalid[g]),
            .bus_req_ready (bready[g]),
            .bus_req_addr  (baddr[g]),
            .bus_resp_valid(brv[g]),
            .bus_resp_data (bdata[g][8*BB-1:0]),
            .resp_valid    (rvalid[g]),
            .resp_ready    (rready[g]),
            .resp_data     (rdata[g]),
            .resp_err      (rerr[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    // 0: zero-wait bus, 1: random stalls/delays, 2: fixed 3-cycle delay
    int mode = 0;

    logic [7:0]  mem[int unsigned];
    int unsigned pq_a[3][$];
    int          pq_d[3][$];
    int unsigned log_a[3][$];

    function automatic int bb_of(input int d);
        return (d == 1) ? 8 : 4;
    endfunction

    function automatic logic [7:0] rd_byte(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 8'((a * 32'd157) ^ (a >> 9) ^ (a >> 17));
    endfunction

    function automatic logic [63:0] beat(input int unsigned a, input int bb);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < bb; i++) r[8*i +: 8] = rd_byte(a + i);
        return r;
    endfunction

    task automatic put_word(input int unsigned a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + i] = w[8*i +: 8];
    endtask

    // Reference: pick bytes straight out of the flat memory.
    function automatic void model(input int unsigned a, input logic [2:0] op,
                                  input logic [31:0] orig, input int bb,
                                  input bit ue, output logic err,
                                  output logic [31:0] val, output int nrd);
        int size;
        int k;
        size = (op < 2) ? 1 : (op < 4) ? 2 : 4;
        err = 1'b0;
        val = '0;
        nrd = 0;
        if (op == 5 || (!ue && op >= 2 && op <= 4 && (a % size) != 0)) begin
            err = 1'b1;
            return;
        end
        if (op <= 4) begin
            for (int i = 0; i < size; i++)
                val = val | (32'(rd_byte(a + i)) << (8 * i));
            if (op == 0 && val[7]) val = val | 32'hFFFF_FF00;
            if (op == 2 && val[15]) val = val | 32'hFFFF_0000;
            nrd = ((a % bb) + size > bb) ? 2 : 1;
        end else begin
            k = a % 4;
            nrd = 1;
            for (int j = 0; j < 4; j++) begin
                if (op == 6 && j >= 3 - k) val[8*j +: 8] = rd_byte(a + j - 3);
                else if (op == 7 && j < 4 - k) val[8*j +: 8] = rd_byte(a + j);
                else val[8*j +: 8] = orig[8*j +: 8];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: log handshakes at the edge, answer from memory after a delay.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (resetn && bvalid[d] && bready[d]) begin
                pq_a[d].push_back(baddr[d]);
                log_a[d].push_back(baddr[d]);
                pq_d[d].push_back(mode == 0 ? 0 :
                                  mode == 1 ? int'($urandom_range(0, 2)) : 3);
            end
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            bready[d] = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            brv[d]    = 1'b0;
            bdata[d]  = {$urandom, $urandom};
            if (pq_a[d].size() != 0) begin
                if (pq_d[d][0] == 0) begin
                    brv[d]   = 1'b1;
                    bdata[d] = beat(pq_a[d][0], bb_of(d));
                    void'(pq_a[d].pop_front());
                    void'(pq_d[d].pop_front());
                end else begin
                    pq_d[d][0] = pq_d[d][0] - 1;
                end
            end else if (mode == 1 && $urandom_range(0, 3) == 0) begin
                brv[d] = 1'b1;
            end
        end
    end

    task automatic do_load(input int d, input logic [31:0] a,
                           input logic [2:0] op, input logic [31:0] orig,
                           input int hold, input bit lat_chk);
        logic        m_err;
        logic [31:0] m_val;
        logic [31:0] base;
        int          m_nrd;
        int          n;
        string       t;
        model(a, op, orig, bb_of(d), d != 2, m_err, m_val, m_nrd);
        t = $sformatf("d%0d op%0d @%h", d, op, a);
        log_a[d].delete();
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_op[d]    = op;
        req_orig[d]  = orig;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({t, " accept"}, 32'(req_ready[d]), 1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rvalid[d] && n < 200);
        chk({t, " resp_valid"}, 32'(rvalid[d]), 1);
        if (lat_chk)
            chk({t, " latency"}, n, m_err ? 1 : (m_nrd == 2 ? 5 : 3));
        for (int h = 0; h < hold; h++) begin
            chk({t, " hold_data"}, rdata[d], m_val);
            chk({t, " hold_valid"}, 32'(rvalid[d]), 1);
            chk({t, " hold_ready"}, 32'(req_ready[d]), 0);
            @(negedge clk);
        end
        chk({t, " data"}, rdata[d], m_val);
        chk({t, " err"}, 32'(rerr[d]), 32'(m_err));
        rready[d] = 1'b1;
        @(posedge clk);
        #1;
        rready[d] = 1'b0;
        chk({t, " nreads"}, log_a[d].size(), m_nrd);
        base = a & ~32'(bb_of(d) - 1);
        if (m_nrd > 0 && log_a[d].size() > 0)
            chk({t, " addr0"}, log_a[d][0], base);
        if (m_nrd == 2 && log_a[d].size() > 1)
            chk({t, " addr1"}, log_a[d][1], base + 32'(bb_of(d)));
    endtask

    task automatic chk_reset(input int d, input string t);
        chk({t, " req_ready"}, 32'(req_ready[d]), 1);
        chk({t, " bus_req_valid"}, 32'(bvalid[d]), 0);
        chk({t, " bus_req_addr"}, baddr[d], 0);
        chk({t, " resp_valid"}, 32'(rvalid[d]), 0);
        chk({t, " resp_data"}, rdata[d], 0);
        chk({t, " resp_err"}, 32'(rerr[d]), 0);
    endtask

    initial begin
        int n;
        int d;
        logic [31:0] a;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_op[i]    = '0;
            req_orig[i]  = '0;
            rready[i]    = 1'b0;
            bready[i]    = 1'b0;
            brv[i]       = 1'b0;
            bdata[i]     = '0;
        end
        put_word(32'h1000, 32'h80FF_1234);
        put_word(32'h2000, 32'h1122_3344);
        put_word(32'h3000, 32'h4433_2211);
        put_word(32'h3004, 32'h8877_6655);
        mem[32'h4006] = 8'h01;
        mem[32'h4007] = 8'h80;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i, $sformatf("rst d%0d", i));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        do_load(0, 32'h1003, 3'd0, 32'h0, 0, 1);
        do_load(0, 32'h1003, 3'd1, 32'h0, 0, 1);
        do_load(0, 32'h2001, 3'd6, 32'hAABB_CCDD, 0, 1);
        do_load(0, 32'h2002, 3'd7, 32'hAABB_CCDD, 0, 1);
        do_load(0, 32'h2003, 3'd6, 32'hAABB_CCDD, 0, 1);
        do_load(0, 32'h3002, 3'd4, 32'h0, 3, 1);
        do_load(1, 32'h4006, 3'd2, 32'h0, 0, 1);
        do_load(1, 32'h4007, 3'd2, 32'h0, 0, 1);
        do_load(1, 32'h4005, 3'd6, 32'h1234_5678, 0, 1);
        do_load(2, 32'h5001, 3'd2, 32'h0, 0, 1);
        do_load(2, 32'h5000, 3'd5, 32'h0, 0, 1);
        do_load(2, 32'h5004, 3'd4, 32'h0, 0, 1);
        do_load(0, 32'hFFFF_FFFE, 3'd4, 32'h0, 0, 1);

        mode = 1;
        for (int it = 0; it < 300; it++) begin
            d = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
            else a = $urandom;
            do_load(d, a, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 2), 0);
        end

        // Reset while the second beat is outstanding.
        mode = 2;
        repeat (4) @(negedge clk);
        log_a[0].delete();
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'hFFFF_FFFE;
        req_op[0]    = 3'd4;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (log_a[0].size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid second read", log_a[0].size(), 2);
        resetn = 1'b0;
        #1;
        chk_reset(0, "rst_mid");
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst_mid late resp_valid", 32'(rvalid[0]), 0);
        end
        mode = 0;
        repeat (2) @(negedge clk);
        do_load(0, 32'h1003, 3'd0, 32'h0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
